// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

    localparam int unsigned AddrWidth  = 16;
    localparam int unsigned InstrWidth = 16;

    localparam logic [InstrWidth-1:0] NopInstr = '0;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} entries between fetch and decode.
module instr_fetch_unit_fetch_fifo #(
    parameter int unsigned  W         = 32,
    parameter int unsigned  DEPTH     = 2,
    parameter logic [W-1:0] RESET_VAL = '0,
    localparam int unsigned PW        = $clog2(DEPTH),
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: single-outstanding instruction memory requests feeding a
// small PC-tagged instruction FIFO, with branch flush support.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned AW    = AddrWidth,
    parameter int unsigned IW    = InstrWidth,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_count,
    output logic          pc_advance,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    input  logic          flush,
    output logic          if_valid,
    output logic [IW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    input  logic          id_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t ResetEntry = '{pc: '0, instr: IW'(NopInstr)};

    logic          run_q;
    logic          outstanding_q, outstanding_d;
    logic          drop_q, drop_d;
    logic [AW-1:0] pend_pc_q;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  wr_entry;
    fetch_entry_t  rd_entry;

    // A pending response reserves a FIFO slot; with none pending the
    // reservation check reduces to "FIFO not full".
    assign imem_req   = run_q & ~outstanding_q & ~flush & ~fifo_full;
    assign imem_addr  = pc_count;
    assign grant      = imem_req & imem_gnt;
    assign pc_advance = grant;

    assign resp     = imem_rvalid & outstanding_q;
    assign push     = resp & ~drop_q & ~flush;
    assign pop      = if_valid & id_ready;
    assign wr_entry = '{pc: pend_pc_q, instr: imem_rdata};

    assign if_valid = ~fifo_empty;
    assign if_instr = rd_entry.instr;
    assign if_pc    = rd_entry.pc;

    always_comb begin
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (grant) begin
            outstanding_d = 1'b1;
        end else if (resp) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end else if (flush && outstanding_q) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            pend_pc_q     <= '0;
        end else begin
            run_q         <= 1'b1;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            if (grant) begin
                pend_pc_q <= pc_count;
            end
        end
    end

    instr_fetch_unit_fetch_fifo #(
        .W        (AW + IW),
        .DEPTH    (DEPTH),
        .RESET_VAL(ResetEntry)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(flush),
        .push (push),
        .wdata(wr_entry),
        .pop  (pop),
        .rdata(rd_entry),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> outstanding_q);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, latency, backpressure, flush, stall.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] pc_count = '0;
    logic        pc_advance;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        flush = 1'b0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready = 1'b0;

    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .AW   (16),
        .IW   (16),
        .DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_count   (pc_count),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready)
    );

    // One clock cycle: inputs applied 1ns after the edge, outputs settle by +3ns.
    task automatic cyc(input logic [15:0] pc, input logic gnt, input logic rv,
                       input logic [15:0] rd, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        pc_count    = pc;
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        id_ready    = rdy;
        flush       = fl;
        #2;
    endtask

    // Reset, then release mid-cycle; the next cyc() call is cycle 1.
    task automatic do_reset();
        #1;
        rst_n       = 1'b0;
        pc_count    = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b0;
        flush       = 1'b0;
        repeat (2) @(posedge clk);
        #5;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        rst_n    = 1'b0;
        imem_gnt = 1'b1;
        id_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        vectors++; if (imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b want 0", imem_req);
        end
        vectors++; if (pc_advance !== 1'b0) begin
            errors++; $display("FAIL reset_adv: got %b want 0", pc_advance);
        end
        vectors++; if (if_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", if_valid);
        end
        vectors++; if (if_instr !== 16'h0000) begin
            errors++; $display("FAIL reset_instr: got %h want 0000", if_instr);
        end
        vectors++; if (if_pc !== 16'h0000) begin
            errors++; $display("FAIL reset_pc: got %h want 0000", if_pc);
        end
    endtask

    task automatic test_latency();
        do_reset();
        cyc(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        vectors++; if (pc_advance !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL lat_c1: got adv=%b addr=%h want 1/0000", pc_advance, imem_addr);
        end
        cyc(16'h0001, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
        vectors++; if (pc_advance !== 1'b0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL lat_c2: got adv=%b vld=%b want 0/0", pc_advance, if_valid);
        end
        cyc(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        vectors++; if (if_valid !== 1'b1) begin
            errors++; $display("FAIL lat_c3_valid: got %b want 1", if_valid);
        end
        vectors++; if (if_instr !== 16'h1234 || if_pc !== 16'h0000) begin
            errors++; $display("FAIL lat_c3_data: got %h@%h want 1234@0000", if_instr, if_pc);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        cyc(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (pc_advance !== 1'b1) begin
            errors++; $display("FAIL full_c1_adv: got %b want 1", pc_advance);
        end
        cyc(16'h0001, 1'b1, 1'b1, 16'hA000, 1'b0, 1'b0);
        vectors++; if (imem_req !== 1'b0) begin
            errors++; $display("FAIL full_c2_req: got %b want 0", imem_req);
        end
        cyc(16'h0001, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (pc_advance !== 1'b1 || imem_addr !== 16'h0001) begin
            errors++; $display("FAIL full_c3: got adv=%b addr=%h want 1/0001", pc_advance, imem_addr);
        end
        cyc(16'h0002, 1'b1, 1'b1, 16'hA001, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(16'h0002, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
            vectors++; if (imem_req !== 1'b0 || pc_advance !== 1'b0) begin
                errors++;
                $display("FAIL full_hold%0d: got req=%b adv=%b want 0/0", i, imem_req, pc_advance);
            end
        end
        cyc(16'h0002, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        vectors++; if (if_instr !== 16'hA000 || if_pc !== 16'h0000 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_pop0: got %h@%h req=%b want A000@0000 req=0", if_instr, if_pc,
                     imem_req);
        end
        cyc(16'h0002, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        vectors++; if (if_instr !== 16'hA001 || if_pc !== 16'h0001) begin
            errors++; $display("FAIL full_pop1: got %h@%h want A001@0001", if_instr, if_pc);
        end
        vectors++; if (pc_advance !== 1'b1 || imem_addr !== 16'h0002) begin
            errors++; $display("FAIL full_resume: got adv=%b addr=%h want 1/0002", pc_advance, imem_addr);
        end
        cyc(16'h0003, 1'b0, 1'b1, 16'hA002, 1'b0, 1'b0);
        vectors++; if (if_valid !== 1'b0) begin
            errors++; $display("FAIL full_drained: got %b want 0", if_valid);
        end
        cyc(16'h0003, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (if_valid !== 1'b1 || if_instr !== 16'hA002 || if_pc !== 16'h0002) begin
            errors++;
            $display("FAIL full_wrap: got vld=%b %h@%h want 1 A002@0002", if_valid, if_instr, if_pc);
        end
    endtask

    task automatic test_flush_outstanding();
        do_reset();
        cyc(16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (pc_advance !== 1'b1) begin
            errors++; $display("FAIL fo_grant: got %b want 1", pc_advance);
        end
        cyc(16'h0006, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        vectors++; if (imem_req !== 1'b0 || pc_advance !== 1'b0) begin
            errors++; $display("FAIL fo_flush: got req=%b adv=%b want 0/0", imem_req, pc_advance);
        end
        cyc(16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (imem_req !== 1'b0) begin
            errors++; $display("FAIL fo_wait: got req=%b want 0", imem_req);
        end
        cyc(16'h0040, 1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        cyc(16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (if_valid !== 1'b0) begin
            errors++; $display("FAIL fo_dropped: got vld=%b instr=%h want vld 0", if_valid, if_instr);
        end
        vectors++; if (pc_advance !== 1'b1 || imem_addr !== 16'h0040) begin
            errors++; $display("FAIL fo_redirect: got adv=%b addr=%h want 1/0040", pc_advance, imem_addr);
        end
        cyc(16'h0041, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        cyc(16'h0041, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (if_valid !== 1'b1 || if_instr !== 16'hBEEF || if_pc !== 16'h0040) begin
            errors++;
            $display("FAIL fo_new: got vld=%b %h@%h want 1 BEEF@0040", if_valid, if_instr, if_pc);
        end
    endtask

    task automatic test_flush_with_rvalid();
        do_reset();
        cyc(16'h0020, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(16'h0021, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0);
        cyc(16'h0021, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (if_valid !== 1'b1 || pc_advance !== 1'b1) begin
            errors++; $display("FAIL fr_setup: got vld=%b adv=%b want 1/1", if_valid, pc_advance);
        end
        cyc(16'h0022, 1'b1, 1'b1, 16'h2222, 1'b1, 1'b1);
        vectors++; if (imem_req !== 1'b0 || pc_advance !== 1'b0) begin
            errors++; $display("FAIL fr_flush: got req=%b adv=%b want 0/0", imem_req, pc_advance);
        end
        cyc(16'h0080, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (if_valid !== 1'b0) begin
            errors++; $display("FAIL fr_empty: got %b want 0", if_valid);
        end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
            errors++; $display("FAIL fr_reissue: got req=%b addr=%h want 1/0080", imem_req, imem_addr);
        end
        cyc(16'h0080, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (if_valid !== 1'b0) begin
            errors++; $display("FAIL fr_nowrite: got %b want 0", if_valid);
        end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
            vectors++; if (imem_req !== 1'b1 || pc_advance !== 1'b0 || imem_addr !== 16'h0010) begin
                errors++;
                $display("FAIL stall%0d: got req=%b adv=%b addr=%h want 1/0/0010", i, imem_req,
                         pc_advance, imem_addr);
            end
        end
        cyc(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (pc_advance !== 1'b1) begin
            errors++; $display("FAIL stall_grant: got %b want 1", pc_advance);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(16'h0030, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(16'h0031, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
        cyc(16'h0031, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(16'h0032, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (if_valid !== 1'b1 || if_instr !== 16'h3333) begin
            errors++; $display("FAIL rm_setup: got vld=%b instr=%h want 1/3333", if_valid, if_instr);
        end
        rst_n = 1'b0;
        #1;
        vectors++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_instr !== 16'h0000) begin
            errors++;
            $display("FAIL rm_async: got vld=%b req=%b instr=%h want 0/0/0000", if_valid, imem_req,
                     if_instr);
        end
        #1;
        rst_n = 1'b1;
        cyc(16'h0050, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (pc_advance !== 1'b1 || if_valid !== 1'b0) begin
            errors++; $display("FAIL rm_restart: got adv=%b vld=%b want 1/0", pc_advance, if_valid);
        end
        cyc(16'h0051, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        cyc(16'h0051, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        vectors++; if (if_valid !== 1'b1 || if_instr !== 16'h5555 || if_pc !== 16'h0050) begin
            errors++;
            $display("FAIL rm_clean: got vld=%b %h@%h want 1 5555@0050", if_valid, if_instr, if_pc);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fifo_full();
        test_flush_outstanding();
        test_flush_with_rvalid();
        test_gnt_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
